// File: rtl/spi_flash_seq.sv
// rtl/spi_flash_seq.sv - SPI flash frame sequencer (CMD/ADDR/DUMMY/DATA) with page RAM port B streaming
// Optional SPI_FLASH_SEQ_WIP_POLL_EN: after 0x02/0x60 frames, poll SR1 (0x05) until WIP clears.
module spi_flash_seq #(
  parameter int CLK_DIV = 2,
  parameter int CSH_CYC = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_cmd,
  input  logic [23:0] i_addr,
  input  logic        i_exi_addr,
  input  logic [2:0]  i_dum_num,
  input  logic        i_exi_data,
  input  logic [15:0] i_data_num,
  input  logic        i_wr_en,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_ram_addr,
  output logic [7:0]  o_ram_wdata,
  output logic        o_ram_we,
  input  logic [7:0]  i_ram_rdata,
  output logic        o_spi_cs_n,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] END_LAST = 16'((CLK_DIV > 2) ? (CLK_DIV - 2) : 0);
  localparam logic [15:0] GAP_LAST = 16'(CSH_CYC - 1);

  logic [2:0]  state_q, state_d, nxt;
  logic [15:0] tmr_q, tmr_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [7:0]  raddr_q, raddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [23:0] addr_q, addr_d;
  logic        exi_addr_q, exi_addr_d;
  logic [2:0]  dum_q, dum_d;
  logic        exi_data_q, exi_data_d;
  logic [15:0] num_q, num_d;
  logic        wr_q, wr_d;
  logic        stay;
  logic        no_ram_wr;

`ifdef SPI_FLASH_SEQ_WIP_POLL_EN
  logic [7:0]  cmd_q, cmd_d;
  logic        poll_q, poll_d;
  logic        pend_q, pend_d;
  assign no_ram_wr = poll_q;
`else
  assign no_ram_wr = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    done_d     = 1'b0;
    we_d       = 1'b0;
    raddr_d    = raddr_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    exi_addr_d = exi_addr_q;
    dum_d      = dum_q;
    exi_data_d = exi_data_q;
    num_d      = num_q;
    wr_d       = wr_q;
    nxt        = S_END;
    stay       = 1'b0;
`ifdef SPI_FLASH_SEQ_WIP_POLL_EN
    cmd_d      = cmd_q;
    poll_d     = poll_q;
    pend_d     = pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_CMD;
          cs_n_d     = 1'b0;
          tx_d       = i_cmd;
          tmr_d      = 16'd0;
          bit_d      = 3'd0;
          cnt_d      = 16'd0;
          raddr_d    = 8'd0;
          addr_d     = i_addr;
          exi_addr_d = i_exi_addr;
          dum_d      = i_dum_num;
          exi_data_d = i_exi_data;
          num_d      = i_data_num;
          wr_d       = i_wr_en;
`ifdef SPI_FLASH_SEQ_WIP_POLL_EN
          cmd_d      = i_cmd;
          poll_d     = 1'b0;
          pend_d     = 1'b0;
`endif
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (tmr_q != DIV_LAST) begin
          tmr_d = tmr_q + 16'd1;
        end else begin
          tmr_d  = 16'd0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[6:0], i_spi_miso};
            if (state_q == S_DATA && !wr_q && bit_q == 3'd7 && !no_ram_wr) begin
              we_d    = 1'b1;
              raddr_d = cnt_q[7:0];
              wdata_d = {rx_q[6:0], i_spi_miso};
            end
          end else if (bit_q != 3'd7) begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end else begin
            // Byte boundary: either the next byte of this phase or the first byte of the next phase
            bit_d = 3'd0;
            stay  = (state_q == S_ADDR  && cnt_q != 16'd2) ||
                    (state_q == S_DUMMY && (cnt_q + 16'd1) != {13'd0, dum_q}) ||
                    (state_q == S_DATA  && (cnt_q + 16'd1) != num_q);
            if (state_q == S_CMD && exi_addr_q)
              nxt = S_ADDR;
            else if ((state_q == S_CMD || state_q == S_ADDR) && dum_q != 3'd0)
              nxt = S_DUMMY;
            else if (state_q != S_DATA && exi_data_q && num_q != 16'd0)
              nxt = S_DATA;
            else
              nxt = S_END;
            if (stay) begin
              cnt_d = cnt_q + 16'd1;
            end else begin
              cnt_d   = 16'd0;
              state_d = nxt;
            end
            case (state_d)
              S_ADDR:  tx_d = (cnt_d[1:0] == 2'd0) ? addr_q[23:16] :
                              (cnt_d[1:0] == 2'd1) ? addr_q[15:8] : addr_q[7:0];
              S_DATA: begin
                if (wr_q) begin
                  tx_d    = i_ram_rdata;
                  raddr_d = cnt_d[7:0] + 8'd1;
                end else begin
                  tx_d = 8'h00;
                end
              end
              default: tx_d = 8'h00;
            endcase
          end
        end
      end
      S_END: begin
        if (tmr_q >= END_LAST) begin
          cs_n_d  = 1'b1;
          state_d = S_GAP;
          tmr_d   = 16'd0;
`ifdef SPI_FLASH_SEQ_WIP_POLL_EN
          if (poll_q ? rx_q[0] : (cmd_q == 8'h02 || cmd_q == 8'h60))
            pend_d = 1'b1;
          else
            done_d = 1'b1;
`else
          done_d  = 1'b1;
`endif
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_GAP: begin
        if (tmr_q >= GAP_LAST) begin
          state_d = S_IDLE;
          tmr_d   = 16'd0;
`ifdef SPI_FLASH_SEQ_WIP_POLL_EN
          if (pend_q) begin
            state_d    = S_CMD;
            cs_n_d     = 1'b0;
            tx_d       = 8'h05;
            cmd_d      = 8'h05;
            bit_d      = 3'd0;
            cnt_d      = 16'd0;
            exi_addr_d = 1'b0;
            dum_d      = 3'd0;
            exi_data_d = 1'b1;
            num_d      = 16'd1;
            wr_d       = 1'b0;
            poll_d     = 1'b1;
            pend_d     = 1'b0;
          end
`endif
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= 16'd0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      bit_q      <= 3'd0;
      cnt_q      <= 16'd0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      raddr_q    <= 8'h00;
      wdata_q    <= 8'h00;
      addr_q     <= 24'h0;
      exi_addr_q <= 1'b0;
      dum_q      <= 3'd0;
      exi_data_q <= 1'b0;
      num_q      <= 16'd0;
      wr_q       <= 1'b0;
`ifdef SPI_FLASH_SEQ_WIP_POLL_EN
      cmd_q      <= 8'h00;
      poll_q     <= 1'b0;
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      done_q     <= done_d;
      we_q       <= we_d;
      raddr_q    <= raddr_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      exi_addr_q <= exi_addr_d;
      dum_q      <= dum_d;
      exi_data_q <= exi_data_d;
      num_q      <= num_d;
      wr_q       <= wr_d;
`ifdef SPI_FLASH_SEQ_WIP_POLL_EN
      cmd_q      <= cmd_d;
      poll_q     <= poll_d;
      pend_q     <= pend_d;
`endif
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_ram_addr  = raddr_q;
  assign o_ram_wdata = wdata_q;
  assign o_ram_we    = we_q;
  assign o_spi_cs_n  = cs_n_q;
  assign o_spi_sclk  = sclk_q;
  assign o_spi_mosi  = tx_q[7] & ~cs_n_q;
endmodule

// File: doc/spi_flash_seq.md
Name: spi_flash_seq

Overview:
- Transaction sequencer for the SPI flash command path.
- Accepts one command descriptor (opcode, address, dummy count, data count, direction) from the command-translation stage.
- Drives the SPI pins through the CMD, ADDR, DUMMY and DATA phases.
- Streams page data through port B of the 256x8 page RAM: reads it for programs, writes it for reads.

Parameters:
- CLK_DIV, 2, SCLK half-period in i_clk cycles (≥1); bit period = 2*CLK_DIV.
- CSH_CYC, 4, minimum i_clk cycles CS_n stays high between frames.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  descriptor valid pulse; accepted only when o_busy=0
- i_cmd  in  8  opcode
- i_addr  in  24  flash address
- i_exi_addr  in  1  1: send 3 address bytes
- i_dum_num  in  3  dummy byte count (0-7)
- i_exi_data  in  1  1: data phase present
- i_data_num  in  16  data byte count
- i_wr_en  in  1  1: data from RAM to flash; 0: data from flash to RAM
- o_busy  out  1  high from accept until CSH_CYC expires
- o_done  out  1  one-cycle pulse at frame end
- o_ram_addr  out  8  page RAM port B address
- o_ram_wdata  out  8  page RAM port B write data
- o_ram_we  out  1  page RAM port B write strobe
- i_ram_rdata  in  8  page RAM port B read data; 1-cycle latency
- o_spi_cs_n  out  1  chip select, active low
- o_spi_sclk  out  1  SPI clock, mode 0
- o_spi_mosi  out  1  serial out, MSB first
- i_spi_miso  in  1  serial in

Behaviour:
- Reset values:
  - o_spi_cs_n=1; all other outputs 0.
  - FSM=IDLE, counters 0.
  - Reset mid-frame aborts at once: CS_n high, SCLK low; no o_done, no RAM write.
- Accept:
  - i_start with o_busy=0 latches all descriptor inputs; later input changes are ignored.
  - i_start while busy is dropped; there is no queue.
- States: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> END -> GAP -> IDLE.
  - ADDR is skipped if i_exi_addr=0.
  - DUMMY is skipped if i_dum_num=0.
  - DATA is skipped if i_exi_data=0 or i_data_num=0.
- Frame start:
  - Cycle after accept: CS_n=0 and MOSI=cmd[7].
  - SCLK rises CLK_DIV cycles later, falls CLK_DIV after that.
  - MOSI updates on each SCLK fall; MISO is sampled on each SCLK rise.
- Byte order:
  - Address is sent addr[23:16], then [15:8], then [7:0].
  - Dummy bytes drive MOSI=0 and discard MISO.
- Data phase, write (i_wr_en=1):
  - Byte k is sourced from RAM address k[7:0].
  - The RAM read is issued ≥2 cycles before the byte's first bit, i.e. prefetched during the previous byte.
- Data phase, read (i_wr_en=0):
  - After the 8th rising edge of byte k, o_ram_we pulses 1 cycle with o_ram_addr=k[7:0] and o_ram_wdata=the shifted byte.
- Counting:
  - Byte counter is 16 bits; RAM address is its low 8 bits, so it wraps 255->0 when data_num > 256.
  - Total SCLK pulses = 8*(1 + 3*exi_addr + dum_num + (exi_data ? data_num : 0)).
- Frame end:
  - END: after the final SCLK fall, hold CS_n low CLK_DIV cycles.
  - Then CS_n=1 and o_done pulses in the same cycle.
  - GAP: CS_n held high CSH_CYC cycles, then o_busy=0.
- Idle levels: SCLK and MOSI stay 0 whenever CS_n=1.

Optional Feature:
- Macro: SPI_FLASH_SEQ_WIP_POLL_EN.
- Defined:
  - After a frame with cmd 0x02 or 0x60, the block autonomously issues 0x05 (read SR1, 1 data byte, no RAM write) frames.
  - Each poll frame is separated by CSH_CYC.
  - Polling repeats until the returned bit0=0.
  - o_done pulses only at the end of the poll frame that returns bit0=0; o_busy stays high throughout.
- Undefined: no polling; o_done pulses at the end of every frame.

Test Plan:
- CLK_DIV=2, cmd 0x06, no addr/dummy/data -> 8 SCLK pulses, MOSI 0,0,0,0,0,1,1,0, CS_n low 33 cycles, one o_done, o_ram_we never high.
- cmd 0x03, addr 0x123456, data_num 1, MISO shifts 0xA5 -> 40 SCLK pulses, MOSI bytes 03 12 34 56, one RAM write addr 0x00 data 0xA5.
- cmd 0x90, dum_num 2, data_num 3, read, MISO returns EF,17,00 -> 48 SCLK pulses, MOSI 90 00 00 then 0s, RAM[0..2]=EF,17,00.
- RAM preloaded RAM[i]=i, cmd 0x02, addr 0x000100, data_num 256, wr_en=1 -> 2080 SCLK pulses, MOSI data bytes 00..FF in order, no gaps in SCLK.
- i_start pulsed mid-frame -> ignored; i_rst asserted during ADDR -> CS_n=1, SCLK=0, o_busy=0 immediately, no o_done; next i_start then runs a normal frame.
- With SPI_FLASH_SEQ_WIP_POLL_EN, cmd 0x60, SR1 returns 0x01, 0x01, 0x00 -> three 0x05 poll frames, single o_done after the third.
